// File: rtl/cnt_seq_pkg.sv
// Shared types and default timing constants for the counter-chain sequencer.
package cnt_seq_pkg;

  typedef enum logic [2:0] {IDLE, RUN, STEP, LOAD, CLEAR} state_t;

  localparam int DB_N_DEF     = 4;
  localparam int DIV_DEF      = 1000;
  localparam int SCAN_DIV_DEF = 500;

  localparam int NUM_BTN = 4;
  localparam int B_RUN   = 0;
  localparam int B_STEP  = 1;
  localparam int B_LOAD  = 2;
  localparam int B_CLR   = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// Button/tick inputs and chain/display outputs of the sequencer.
interface cnt_seq_ctrl_if;
  logic       tick;
  logic       btn_run;
  logic       btn_step;
  logic       btn_load;
  logic       btn_clr;
  logic       auto_scan;
  logic [1:0] ptr_sel;
  logic       ce_out;
  logic       load_out;
  logic       chain_clr;
  logic [1:0] ptr;
  logic       running;

  modport master (
    output tick, btn_run, btn_step, btn_load, btn_clr, auto_scan, ptr_sel,
    input  ce_out, load_out, chain_clr, ptr, running
  );

  modport slave (
    input  tick, btn_run, btn_step, btn_load, btn_clr, auto_scan, ptr_sel,
    output ce_out, load_out, chain_clr, ptr, running
  );
endinterface

// File: rtl/btn_debounce.sv
// Tick-sampled button debouncer: a level is accepted after DB_N agreeing
// samples; a rising accepted level emits a one-cycle press pulse.
module btn_debounce
  import cnt_seq_pkg::*;
#(
  parameter int DB_N = DB_N_DEF
) (
  input  logic clk,
  input  logic clr_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = cw(DB_N);

  logic [1:0]    r_sync;
  logic          r_acc;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // r_cnt holds how many consecutive samples already disagreed with r_acc.
  assign w_flip = i_tick && (r_sync[1] != r_acc) && (r_cnt == CW'(DB_N - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync  <= '0;
      r_acc   <= 1'b0;
      r_cnt   <= '0;
      o_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      o_press <= w_flip && r_sync[1];
      if (i_tick) begin
        if ((r_sync[1] == r_acc) || w_flip) r_cnt <= '0;
        else                                r_cnt <= r_cnt + 1'b1;
        if (w_flip) r_acc <= r_sync[1];
      end
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Run/stop/step/load/clear sequencer for the counter chain, with RUN rate
// divider and display digit-pointer scanner.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int DB_N     = DB_N_DEF,
  parameter int DIV      = DIV_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic           clk,
  input  logic           clr_n,
  cnt_seq_ctrl_if.slave  bus
);

  localparam int DW = cw(DIV);
  localparam int SW = cw(SCAN_DIV);

  logic [NUM_BTN-1:0] w_btn;
  logic [NUM_BTN-1:0] w_press;

  assign w_btn = {bus.btn_clr, bus.btn_load, bus.btn_step, bus.btn_run};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(.DB_N(DB_N)) u_db (
      .clk     (clk),
      .clr_n   (clr_n),
      .i_tick  (bus.tick),
      .i_btn   (w_btn[g]),
      .o_press (w_press[g])
    );
  end

  state_t        r_state, w_next;
  logic          r_org;
  logic [DW-1:0] r_div;
  logic [SW-1:0] r_scan;
  logic          w_div_wrap;
  logic          w_run_hold;

  assign w_div_wrap = bus.tick && (r_div == DW'(DIV - 1));
  assign w_run_hold = (r_state == RUN) && (w_next == RUN);

  // Priority clr > load > run > step; lower presses in the same cycle are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if      (w_press[B_LOAD]) w_next = LOAD;
        else if (w_press[B_RUN])  w_next = RUN;
        else if (w_press[B_STEP]) w_next = STEP;
      end
      RUN: begin
        if      (w_press[B_LOAD]) w_next = LOAD;
        else if (w_press[B_RUN])  w_next = IDLE;
      end
      STEP:    w_next = IDLE;
      LOAD:    w_next = r_org ? RUN : IDLE;
      CLEAR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_press[B_CLR]) w_next = CLEAR;
  end

  // Outputs are registered from the next state so each command pulse
  // coincides exactly with the cycle the FSM sits in that state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state       <= IDLE;
      r_org         <= 1'b0;
      r_div         <= '0;
      bus.ce_out    <= 1'b0;
      bus.load_out  <= 1'b0;
      bus.chain_clr <= 1'b0;
      bus.running   <= 1'b0;
    end else begin
      r_state       <= w_next;
      bus.ce_out    <= (w_next == STEP) || (w_run_hold && w_div_wrap);
      bus.load_out  <= (w_next == LOAD);
      bus.chain_clr <= (w_next == CLEAR);
      bus.running   <= (w_next == RUN) || ((w_next == LOAD) && (r_state == RUN));
      if (w_next == LOAD) r_org <= (r_state == RUN);
      if ((w_next == CLEAR) || ((r_state == IDLE) && (w_next == RUN)))
        r_div <= '0;
      else if (w_run_hold && bus.tick)
        r_div <= w_div_wrap ? '0 : r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_scan  <= '0;
      bus.ptr <= 2'd0;
    end else if (!bus.auto_scan) begin
      r_scan  <= '0;
      bus.ptr <= bus.ptr_sel;
    end else if (bus.tick) begin
      if (r_scan == SW'(SCAN_DIV - 1)) begin
        r_scan  <= '0;
        bus.ptr <= bus.ptr + 2'd1;
      end else begin
        r_scan  <= r_scan + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Scenario bench for cnt_seq_ctrl: DB_N=3, DIV=4, SCAN_DIV=2, tick every 5 cycles.
module tb_cnt_seq_ctrl;
  import cnt_seq_pkg::*;

  typedef struct packed {
    int         cyc;
    logic [1:0] kind;
  } evt_t;

  localparam logic [1:0] K_CE = 2'd0, K_LD = 2'd1, K_CLR = 2'd2, K_BAD = 2'd3;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   c_run  = 0;
  evt_t exp_q[$];
  evt_t obs_q[$];

  cnt_seq_ctrl_if bus();

  cnt_seq_ctrl #(.DB_N(3), .DIV(4), .SCAN_DIV(2)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  // Cycle counter and 1-in-5 tick, updated just after each rising edge.
  initial begin
    bus.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.tick = (cyc % 5 == 4);
    end
  end

  // Record every command pulse with the cycle it appeared in.
  initial begin
    evt_t m;
    forever begin
      @(negedge clk);
      m.cyc = cyc;
      if (int'(bus.ce_out) + int'(bus.load_out) + int'(bus.chain_clr) > 1) begin
        m.kind = K_BAD; obs_q.push_back(m);
      end else if (bus.ce_out) begin
        m.kind = K_CE; obs_q.push_back(m);
      end else if (bus.load_out) begin
        m.kind = K_LD; obs_q.push_back(m);
      end else if (bus.chain_clr) begin
        m.kind = K_CLR; obs_q.push_back(m);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int next_c(input int margin);
    return ((cyc + margin) / 5 + 1) * 5;
  endfunction

  function automatic evt_t mk(input int c, input logic [1:0] k);
    evt_t e;
    e.cyc  = c;
    e.kind = k;
    return e;
  endfunction

  task automatic test_reset();
    bus.btn_run = 0; bus.btn_step = 0; bus.btn_load = 0; bus.btn_clr = 0;
    bus.auto_scan = 0; bus.ptr_sel = 2'd0;
    clr_n = 0;
    wait_cyc(3);
    checks++;
    if ({bus.ce_out, bus.load_out, bus.chain_clr, bus.running} !== 4'b0000) begin
      errors++; $display("FAIL reset_out: got %b want 0000",
                         {bus.ce_out, bus.load_out, bus.chain_clr, bus.running});
    end
    checks++;
    if (bus.ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", bus.ptr); end
    clr_n = 1;
    wait_cyc(10);
    checks++;
    if ({bus.ce_out, bus.load_out, bus.chain_clr, bus.running} !== 4'b0000) begin
      errors++; $display("FAIL post_reset_out: got %b want 0000",
                         {bus.ce_out, bus.load_out, bus.chain_clr, bus.running});
    end
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL post_reset_state: got %0d want IDLE", dut.r_state); end
  endtask

  // Run press seen at ticks c+4,+9,+14 -> RUN at c+16; ce every 4 ticks after.
  task automatic test_run();
    evt_t e, o;
    c_run = next_c(2);
    wait_cyc(c_run);
    bus.btn_run = 1;
    exp_q.push_back(mk(c_run + 35, K_CE));
    exp_q.push_back(mk(c_run + 55, K_CE));
    wait_cyc(c_run + 15);
    checks++;
    if (bus.running !== 1'b0) begin errors++; $display("FAIL run_early: running got %b want 0", bus.running); end
    wait_cyc(c_run + 16);
    checks++;
    if (bus.running !== 1'b1) begin errors++; $display("FAIL run_entry: running got %b want 1", bus.running); end
    wait_cyc(c_run + 20);
    bus.btn_run = 0;
    wait_cyc(c_run + 60);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL run_evt: missing kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL run_evt: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", o.kind, o.cyc, e.kind, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL run_extra: %0d extra pulses, first kind=%0d cyc=%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  // Load lands at c_run+86 with the divider at 2; two more ticks give ce at +95.
  task automatic test_load_origin();
    evt_t e, o;
    wait_cyc(c_run + 70);
    bus.btn_load = 1;
    exp_q.push_back(mk(c_run + 75, K_CE));
    exp_q.push_back(mk(c_run + 86, K_LD));
    exp_q.push_back(mk(c_run + 95, K_CE));
    wait_cyc(c_run + 85);
    bus.btn_load = 0;
    wait_cyc(c_run + 86);
    checks++;
    if (bus.running !== 1'b1) begin errors++; $display("FAIL load_running: got %b want 1", bus.running); end
    wait_cyc(c_run + 87);
    checks++;
    if (dut.r_state !== RUN) begin errors++; $display("FAIL load_return: got %0d want RUN", dut.r_state); end
    wait_cyc(c_run + 90);
    bus.btn_run = 1;
    wait_cyc(c_run + 106);
    checks++;
    if (bus.running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b want 0", bus.running); end
    wait_cyc(c_run + 110);
    bus.btn_run = 0;
    wait_cyc(c_run + 130);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL load_evt: missing kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL load_evt: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", o.kind, o.cyc, e.kind, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL load_extra: %0d extra pulses, first kind=%0d cyc=%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  // Alternating samples never reach 3 in a row; hold from c+50 accepts at tick c+64.
  task automatic test_bounce();
    evt_t e, o;
    int c;
    c = next_c(5);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(c + 5 * i);
      bus.btn_step = (i % 2 == 0);
    end
    wait_cyc(c + 50);
    bus.btn_step = 1;
    exp_q.push_back(mk(c + 66, K_CE));
    wait_cyc(c + 66);
    checks++;
    if (dut.r_state !== STEP) begin errors++; $display("FAIL bounce_step: got %0d want STEP", dut.r_state); end
    wait_cyc(c + 67);
    checks++;
    if (dut.r_state !== IDLE || bus.running !== 1'b0) begin
      errors++; $display("FAIL bounce_idle: state %0d running %b want IDLE/0", dut.r_state, bus.running);
    end
    wait_cyc(c + 70);
    bus.btn_step = 0;
    wait_cyc(c + 95);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL bounce_evt: missing kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL bounce_evt: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", o.kind, o.cyc, e.kind, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL bounce_extra: %0d extra pulses, first kind=%0d cyc=%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_priority();
    evt_t e, o;
    int c;
    c = next_c(5);
    wait_cyc(c);
    bus.btn_clr  = 1;
    bus.btn_load = 1;
    exp_q.push_back(mk(c + 16, K_CLR));
    wait_cyc(c + 17);
    checks++;
    if (dut.r_state !== IDLE || bus.running !== 1'b0) begin
      errors++; $display("FAIL prio_idle: state %0d running %b want IDLE/0", dut.r_state, bus.running);
    end
    wait_cyc(c + 20);
    bus.btn_clr  = 0;
    bus.btn_load = 0;
    wait_cyc(c + 45);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL prio_evt: missing kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL prio_evt: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", o.kind, o.cyc, e.kind, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL prio_extra: %0d extra pulses, first kind=%0d cyc=%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_pointer();
    int c;
    int pq_cyc[$];
    int pq_val[$];
    int pc, pv;
    c = next_c(5);
    wait_cyc(c);
    bus.auto_scan = 1;
    pq_cyc = '{c + 9, c + 10, c + 19, c + 20, c + 30, c + 40};
    pq_val = '{0, 1, 1, 2, 3, 0};
    while (pq_cyc.size() != 0) begin
      pc = pq_cyc.pop_front();
      pv = pq_val.pop_front();
      wait_cyc(pc);
      checks++;
      if (int'(bus.ptr) != pv) begin errors++; $display("FAIL ptr_scan: cyc %0d got %0d want %0d", pc, bus.ptr, pv); end
    end
    wait_cyc(c + 42);
    bus.auto_scan = 0;
    bus.ptr_sel   = 2'd2;
    wait_cyc(c + 43);
    checks++;
    if (bus.ptr !== 2'd2) begin errors++; $display("FAIL ptr_manual: got %0d want 2", bus.ptr); end
    wait_cyc(c + 45);
    bus.auto_scan = 1;
    wait_cyc(c + 54);
    checks++;
    if (bus.ptr !== 2'd2) begin errors++; $display("FAIL ptr_resume_hold: got %0d want 2", bus.ptr); end
    wait_cyc(c + 55);
    checks++;
    if (bus.ptr !== 2'd3) begin errors++; $display("FAIL ptr_resume_step: got %0d want 3", bus.ptr); end
  endtask

  // clr_n dropped inside the STEP cycle: the ce pulse must vanish at once.
  task automatic test_abort();
    int c;
    c = next_c(5);
    wait_cyc(c);
    bus.auto_scan = 0;
    bus.ptr_sel   = 2'd1;
    bus.btn_step  = 1;
    wait_cyc(c + 16);
    checks++;
    if (bus.ce_out !== 1'b1) begin errors++; $display("FAIL abort_pre: ce_out got %b want 1", bus.ce_out); end
    #1;
    clr_n = 0;
    bus.btn_step = 0;
    #1;
    checks++;
    if ({bus.ce_out, bus.load_out, bus.chain_clr, bus.running} !== 4'b0000) begin
      errors++; $display("FAIL abort_out: got %b want 0000",
                         {bus.ce_out, bus.load_out, bus.chain_clr, bus.running});
    end
    checks++;
    if (bus.ptr !== 2'd0) begin errors++; $display("FAIL abort_ptr: got %0d want 0", bus.ptr); end
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL abort_state: got %0d want IDLE", dut.r_state); end
    wait_cyc(c + 20);
    clr_n = 1;
    wait_cyc(c + 40);
    checks++;
    if (bus.ptr !== 2'd1) begin errors++; $display("FAIL abort_ptr_after: got %0d want 1", bus.ptr); end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL abort_extra: %0d pulses, first kind=%0d cyc=%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_origin();
    test_bounce();
    test_priority();
    test_pointer();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
